// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer for the 1 KiB InstructionMemory: owns the fetch PC, tracks the one-cycle
// synchronous read and buffers returned words in a 2-entry skid FIFO for decode.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] ReadAddress,
  input  logic [31:0]       Instruction,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              misalign_err,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic              inflight_reg, inflight_next;
  logic [ADDR_W-1:0] inflight_pc_reg, inflight_pc_next;
  logic [1:0]        count_reg, count_next;
  logic              wr_ptr_reg, wr_ptr_next;
  logic              rd_ptr_reg, rd_ptr_next;
  logic [1:0]        state_reg, state_next;
  logic              misalign_reg;

  logic              pop;
  logic              push;
  logic              issue;
  logic              pending;
  logic [2:0]        occupancy;

  logic [31:0]       entry_instr [DEPTH];
  logic [ADDR_W-1:0] entry_pc    [DEPTH];
  logic [DEPTH-1:0]  entry_we;

  assign pop  = out_valid & out_ready;
  // Returning data is only captured when no redirect kills it at the same edge.
  assign push = inflight_reg & ~redirect_valid;

  // Occupancy after this edge's pop, counting the read that is still in flight.
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue     = fetch_en & ~redirect_valid & (occupancy < 3'd2);

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    inflight_pc_next = inflight_pc_reg;
    inflight_next    = issue;
    count_next       = count_reg + {1'b0, push} - {1'b0, pop};
    wr_ptr_next      = wr_ptr_reg ^ push;
    rd_ptr_next      = rd_ptr_reg ^ pop;
    if (redirect_valid) begin
      fetch_pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
      count_next    = 2'd0;
      wr_ptr_next   = 1'b0;
      rd_ptr_next   = 1'b0;
    end else if (issue) begin
      fetch_pc_next    = fetch_pc_reg + ADDR_W'(4);
      inflight_pc_next = fetch_pc_reg;
    end
  end

  assign pending = inflight_next | (count_next != 2'd0);

  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE:           state_next = fetch_en ? ST_RUN : ST_IDLE;
      ST_RUN, ST_DRAIN:  state_next = fetch_en ? ST_RUN : (pending ? ST_DRAIN : ST_IDLE);
      default:           state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      count_reg       <= 2'd0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      state_reg       <= ST_IDLE;
      misalign_reg    <= 1'b0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
      count_reg       <= count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      state_reg       <= state_next;
      misalign_reg    <= redirect_valid & (|redirect_pc[1:0]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0]       instr_reg;
      logic [ADDR_W-1:0] pc_reg;

      assign entry_we[gi] = push & (wr_ptr_reg == 1'(gi));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          instr_reg <= '0;
          pc_reg    <= '0;
        end else if (entry_we[gi]) begin
          instr_reg <= Instruction;
          pc_reg    <= inflight_pc_reg;
        end
      end

      assign entry_instr[gi] = instr_reg;
      assign entry_pc[gi]    = pc_reg;
    end
  endgenerate

  // A push can only land in a full FIFO if the issue throttle is broken.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(push && count_reg == 2'd2));
    end
  end

  assign ReadAddress  = fetch_pc_reg;
  assign out_valid    = (count_reg != 2'd0);
  assign out_instr    = entry_instr[rd_ptr_reg];
  assign out_pc       = entry_pc[rd_ptr_reg];
  assign misalign_err = misalign_reg;
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a byte-wide memory plus a queue-based model of the fetch
// stream, compared against the DUT outputs every cycle under directed and random stimulus.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic [9:0]  ReadAddress;
  logic [31:0] Instruction = '0;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [9:0]  out_pc;
  logic        misalign_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [1024];

  // Model state: architectural PC, pending read, queue of buffered PCs.
  logic [9:0] m_pc;
  logic       m_inflight;
  logic [9:0] m_inflight_pc;
  logic [9:0] m_q [$];
  logic       m_busy;
  logic       m_mis;

  instruction_fetch_unit #(.ADDR_W(10), .RESET_PC(10'h000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .ReadAddress    (ReadAddress),
    .Instruction    (Instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [9:0] a);
    return {mem[a], mem[a + 10'd1], mem[a + 10'd2], mem[a + 10'd3]};
  endfunction

  // Synchronous memory: data for the address sampled at an edge appears after that edge.
  always @(posedge clk) Instruction <= word_at(ReadAddress);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc          = 10'h000;
    m_inflight    = 1'b0;
    m_inflight_pc = 10'h000;
    m_q.delete();
    m_busy        = 1'b0;
    m_mis         = 1'b0;
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("out_pc", 32'(out_pc), 32'(m_q[0]));
      check("out_instr", out_instr, word_at(m_q[0]));
    end
    check("ReadAddress", 32'(ReadAddress), 32'(m_pc));
    check("busy", 32'(busy), 32'(m_busy));
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
  endtask

  // Called at a negedge: drive inputs, predict the next edge, then check at the following negedge.
  task automatic step(input logic fe, input logic rv, input logic [9:0] rpc, input logic rdy);
    logic pop;
    logic issue;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    pop = (m_q.size() != 0) && rdy;
    if (rv) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_pc       = {rpc[9:2], 2'b00};
      m_mis      = (rpc[1:0] != 2'b00);
      m_busy     = fe;
    end else begin
      issue = fe && ((m_q.size() + int'(m_inflight) - int'(pop)) < 2);
      m_mis = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back(m_inflight_pc);
      if (issue) begin
        m_inflight    = 1'b1;
        m_inflight_pc = m_pc;
        m_pc          = m_pc + 10'd4;
      end else begin
        m_inflight = 1'b0;
      end
      m_busy = fe || (m_busy && (m_inflight || m_q.size() != 0));
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    reset_n        = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_out_instr", out_instr, 32'h0);
    check("reset_out_pc", 32'(out_pc), 32'h0);
    reset_n = 1'b1;

    // Stream from reset with decode always ready.
    repeat (6) step(1'b1, 1'b0, 10'h0, 1'b1);
    // Decode stalls, FIFO saturates, then drains in order.
    repeat (5) step(1'b1, 1'b0, 10'h0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 10'h0, 1'b1);
    // Redirect while the FIFO is full.
    repeat (3) step(1'b1, 1'b0, 10'h0, 1'b0);
    step(1'b1, 1'b1, 10'h100, 1'b0);
    repeat (5) step(1'b1, 1'b0, 10'h0, 1'b1);
    // Misaligned redirect near the top of memory, wrapping to 0.
    step(1'b1, 1'b1, 10'h3FE, 1'b1);
    repeat (6) step(1'b1, 1'b0, 10'h0, 1'b1);
    // Drop fetch_en with a read in flight and one word buffered.
    step(1'b0, 1'b0, 10'h0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 10'h0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 10'h0, 1'b1);
    // Redirect while draining.
    repeat (3) step(1'b1, 1'b0, 10'h0, 1'b0);
    step(1'b0, 1'b0, 10'h0, 1'b0);
    step(1'b0, 1'b1, 10'h044, 1'b0);
    repeat (3) step(1'b0, 1'b0, 10'h0, 1'b1);

    // Asynchronous reset mid-stream, checked before the next edge.
    repeat (4) step(1'b1, 1'b0, 10'h0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) step(1'b1, 1'b0, 10'h0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0, 10'($urandom),
           $urandom_range(0, 3) != 0);
    end
    repeat (8) step(1'b0, 1'b0, 10'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
